// File: rtl/mem_writer.sv
// mem_writer: splits a byte/halfword/word store into little-endian single-byte RAM writes.
// Define MEM_WRITER_ALIGN_CHECK_EN to reject misaligned halfword and word stores.
module mem_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  width_i,
    input  logic        stall_RAM_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] addr_RAM_o,
    output logic [7:0]  data_RAM_o,
    output logic        wr_RAM_o
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t      r_state,    w_state_nxt;
    logic [31:0] r_addr,     w_addr_nxt;
    logic [31:0] r_data,     w_data_nxt;
    logic [2:0]  r_cnt,      w_cnt_nxt;
    logic [1:0]  r_idx,      w_idx_nxt;
    logic        r_err,      w_err_nxt;
    logic [31:0] r_addr_ram, w_addr_ram_nxt;
    logic [7:0]  r_data_ram, w_data_ram_nxt;

    logic        w_reject;
    logic [2:0]  w_cnt_req;
    logic [1:0]  w_idx_inc;
    logic        w_last;
    logic        w_advance;

    always_comb begin
        w_reject = (width_i == 2'b11);
`ifdef MEM_WRITER_ALIGN_CHECK_EN
        if ((width_i == 2'b01 && addr_i[0]) || (width_i == 2'b10 && addr_i[1:0] != 2'b00))
            w_reject = 1'b1;
`endif
    end

    always_comb begin
        case (width_i)
            2'b00:   w_cnt_req = 3'd1;
            2'b01:   w_cnt_req = 3'd2;
            default: w_cnt_req = 3'd4;
        endcase
    end

    assign w_idx_inc = r_idx + 2'd1;
    assign w_last    = (({1'b0, r_idx} + 3'd1) == r_cnt);
    // A byte is retired only when the global ready is up and the RAM is free.
    assign w_advance = rdy && !stall_RAM_i;

    // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_idx;
        w_err_nxt      = r_err;
        w_addr_ram_nxt = r_addr_ram;
        w_data_ram_nxt = r_data_ram;
        case (r_state)
            IDLE: begin
                if (rdy && req_i) begin
                    if (w_reject) begin
                        w_state_nxt = DONE;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt    = WRITE;
                        w_addr_nxt     = addr_i;
                        w_data_nxt     = data_i;
                        w_cnt_nxt      = w_cnt_req;
                        w_idx_nxt      = 2'd0;
                        w_err_nxt      = 1'b0;
                        w_addr_ram_nxt = addr_i;
                        w_data_ram_nxt = data_i[7:0];
                    end
                end
            end
            WRITE: begin
                if (w_advance) begin
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt      = w_idx_inc;
                        w_addr_ram_nxt = r_addr + {30'd0, w_idx_inc};
                        w_data_ram_nxt = r_data[{w_idx_inc, 3'b000} +: 8];
                    end
                end
            end
            DONE: begin
                if (rdy) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_err      <= 1'b0;
            r_addr_ram <= '0;
            r_data_ram <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_err      <= w_err_nxt;
            r_addr_ram <= w_addr_ram_nxt;
            r_data_ram <= w_data_ram_nxt;
        end
    end

    assign busy_o     = (r_state != IDLE);
    assign wr_RAM_o   = (r_state == WRITE);
    assign done_o     = (r_state == DONE);
    assign err_o      = (r_state == DONE) && r_err;
    assign addr_RAM_o = r_addr_ram;
    assign data_RAM_o = r_data_ram;

endmodule

// File: tb/tb_mem_writer.sv
// tb_mem_writer: directed stores checked against a byte-queue model of the expected RAM writes.
module tb_mem_writer;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        req_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [1:0]  width_i;
    logic        stall_RAM_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] addr_RAM_o;
    logic [7:0]  data_RAM_o;
    logic        wr_RAM_o;

    mem_writer dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .width_i     (width_i),
        .stall_RAM_i (stall_RAM_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .addr_RAM_o  (addr_RAM_o),
        .data_RAM_o  (data_RAM_o),
        .wr_RAM_o    (wr_RAM_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    bit  exp_err;
    bit  model_on;
    int  n_written;
    int  n_checks;
    int  n_errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Model: the list of byte writes a store must produce, derived from width and alignment.
    task automatic start_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        bit rej;
        int n;
        rej = (w == 2'b11);
`ifdef MEM_WRITER_ALIGN_CHECK_EN
        if ((w == 2'b01 && a[0]) || (w == 2'b10 && a[1:0] != 2'b00)) rej = 1'b1;
`endif
        n = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
        exp_err = rej;
        if (!rej)
            for (int i = 0; i < n; i++) exp_q.push_back('{addr: a + 32'(i), data: d[8*i +: 8]});
        addr_i  = a;
        data_i  = d;
        width_i = w;
        req_i   = 1'b1;
        tick();
        req_i   = 1'b0;
    endtask

    task automatic check_bus(input string nm, input logic [31:0] a, input logic [7:0] d);
        check({nm, "_wr"},   64'(wr_RAM_o),   64'd1);
        check({nm, "_addr"}, 64'(addr_RAM_o), 64'(a));
        check({nm, "_data"}, 64'(data_RAM_o), 64'(d));
    endtask

    task automatic check_done(input string nm, input logic e);
        check({nm, "_done"}, 64'(done_o),   64'd1);
        check({nm, "_err"},  64'(err_o),    64'(e));
        check({nm, "_wr"},   64'(wr_RAM_o), 64'd0);
    endtask

    task automatic check_idle(input string nm);
        check({nm, "_busy"}, 64'(busy_o), 64'd0);
        check({nm, "_done"}, 64'(done_o), 64'd0);
        check({nm, "_wr"},   64'(wr_RAM_o), 64'd0);
    endtask

    // Compare process: every presented byte must be the head of the expected write list.
    always @(negedge clk) begin
        if (model_on) begin
            if (wr_RAM_o) begin
                check("cmp_write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check("cmp_addr", 64'(addr_RAM_o), 64'(exp_q[0].addr));
                    check("cmp_data", 64'(data_RAM_o), 64'(exp_q[0].data));
                    check("cmp_busy_write", 64'(busy_o), 64'd1);
                    if (rdy && !stall_RAM_i) begin
                        void'(exp_q.pop_front());
                        n_written++;
                    end
                end
            end else if (done_o) begin
                check("cmp_done_err", 64'(err_o), 64'(exp_err));
                check("cmp_done_all_written", 64'(exp_q.size()), 64'd0);
                check("cmp_busy_done", 64'(busy_o), 64'd1);
            end else begin
                check("cmp_idle_busy", 64'(busy_o), 64'd0);
            end
        end
    end

    initial begin
        logic [7:0] t1_bytes [4];
        int n_before;
        t1_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        n_checks = 0; n_errors = 0; n_written = 0;
        model_on = 1'b0; exp_err = 1'b0;
        rdy = 1'b1; req_i = 1'b0; addr_i = '0; data_i = '0; width_i = '0; stall_RAM_i = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check_idle("rst_async");
        check("rst_addr", 64'(addr_RAM_o), 64'd0);
        check("rst_data", 64'(data_RAM_o), 64'd0);
        check("rst_err",  64'(err_o),      64'd0);
        tick();
        tick();
        check_idle("rst_held");
        rst = 1'b1;
        model_on = 1'b1;
        tick();
        check_idle("post_rst");

        // Request while rdy=0 is not accepted.
        rdy = 1'b0; req_i = 1'b1; addr_i = 32'h10; width_i = 2'b00;
        tick();
        check_idle("rdy_low_req");
        req_i = 1'b0; rdy = 1'b1;
        tick();

        // Word store, unstalled.
        start_store(32'h0000_1000, 32'hDEAD_BEEF, 2'b10);
        check("model_t1_b3_addr", 64'(exp_q[3].addr), 64'h1003);
        check("model_t1_b3_data", 64'(exp_q[3].data), 64'hDE);
        for (int i = 0; i < 4; i++) begin
            check_bus("t1_byte", 32'h1000 + 32'(i), t1_bytes[i]);
            tick();
        end
        check_done("t1", 1'b0);
        tick();
        check_idle("t1_after");

        // Byte store.
        start_store(32'h20, 32'h1234_5678, 2'b00);
        check_bus("t2_byte", 32'h20, 8'h78);
        tick();
        check_done("t2", 1'b0);
        tick();

        // Halfword store, RAM stalled during cycles 1-2.
        start_store(32'h40, 32'h0000_AABB, 2'b01);
        stall_RAM_i = 1'b1;
        check_bus("t3_c1", 32'h40, 8'hBB);
        tick();
        check_bus("t3_c2", 32'h40, 8'hBB);
        tick();
        stall_RAM_i = 1'b0;
        check_bus("t3_c3", 32'h40, 8'hBB);
        tick();
        check_bus("t3_c4", 32'h41, 8'hAA);
        tick();
        check_done("t3", 1'b0);
        tick();

        // Word store straddling the top of the address space.
        start_store(32'hFFFF_FFFE, 32'h1122_3344, 2'b10);
`ifdef MEM_WRITER_ALIGN_CHECK_EN
        check_done("t4_misaligned", 1'b1);
        check("t4_hold_addr", 64'(addr_RAM_o), 64'h41);
        check("t4_hold_data", 64'(data_RAM_o), 64'hAA);
        tick();
`else
        check("model_t4_wrap", 64'(exp_q[2].addr), 64'h0);
        check_bus("t4_b0", 32'hFFFF_FFFE, 8'h44);
        tick();
        check_bus("t4_b1", 32'hFFFF_FFFF, 8'h33);
        tick();
        check_bus("t4_b2", 32'h0000_0000, 8'h22);
        tick();
        check_bus("t4_b3", 32'h0000_0001, 8'h11);
        tick();
        check_done("t4", 1'b0);
        tick();
`endif
        check_idle("t4_after");

        // Reserved width: no write, error completion, bus holds.
        start_store(32'h80, 32'h55, 2'b11);
        check_done("t5_reserved", 1'b1);
`ifdef MEM_WRITER_ALIGN_CHECK_EN
        check("t5_hold_addr", 64'(addr_RAM_o), 64'h41);
        check("t5_hold_data", 64'(data_RAM_o), 64'hAA);
`else
        check("t5_hold_addr", 64'(addr_RAM_o), 64'h1);
        check("t5_hold_data", 64'(data_RAM_o), 64'h11);
`endif
        tick();
        check_idle("t5_after");

        // Misaligned halfword.
        start_store(32'h51, 32'h0000_CAFE, 2'b01);
`ifdef MEM_WRITER_ALIGN_CHECK_EN
        check_done("t6_misaligned", 1'b1);
        tick();
`else
        check_bus("t6_b0", 32'h51, 8'hFE);
        tick();
        check_bus("t6_b1", 32'h52, 8'hCA);
        tick();
        check_done("t6", 1'b0);
        tick();
`endif

        // Word store with rdy=0 in cycles 2-3, an ignored request while busy, and a stretched done.
        start_store(32'h200, 32'h0102_0304, 2'b10);
        check_bus("t7_c1", 32'h200, 8'h04);
        tick();
        rdy = 1'b0;
        check_bus("t7_c2", 32'h201, 8'h03);
        tick();
        check_bus("t7_c3", 32'h201, 8'h03);
        tick();
        rdy = 1'b1;
        check_bus("t7_c4", 32'h201, 8'h03);
        tick();
        addr_i = 32'h999; data_i = 32'h77; width_i = 2'b00; req_i = 1'b1;
        check_bus("t7_c5", 32'h202, 8'h02);
        tick();
        req_i = 1'b0;
        check_bus("t7_c6", 32'h203, 8'h01);
        tick();
        check_done("t7_c7", 1'b0);
        rdy = 1'b0;
        tick();
        check_done("t7_c8_stretch", 1'b0);
        rdy = 1'b1;
        tick();
        check_idle("t7_after");

        // Reset in cycle 2 of a word store aborts it after byte 0.
        n_before = n_written;
        start_store(32'h300, 32'hA1B2_C3D4, 2'b10);
        check_bus("t8_c1", 32'h300, 8'hD4);
        tick();
        rst = 1'b0;
        model_on = 1'b0;
        exp_q.delete();
        #1;
        check_idle("t8_rst");
        check("t8_rst_addr", 64'(addr_RAM_o), 64'd0);
        check("t8_rst_data", 64'(data_RAM_o), 64'd0);
        tick();
        rst = 1'b1;
        model_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_idle("t8_no_done");
        end
        check("t8_bytes_written", 64'(n_written - n_before), 64'd1);

        // A fresh store works after the aborted one.
        start_store(32'h400, 32'h0000_005A, 2'b00);
        check_bus("t9_byte", 32'h400, 8'h5A);
        tick();
        check_done("t9", 1'b0);
        tick();
        check("end_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_writer.md
MEM_WRITER -- requirements
Module: mem_writer

Interface
REQ-001 The block SHALL have no parameters; address width is 32 bits and RAM data width is 8 bits.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, independent of clk.
REQ-004 rdy  input  1  global ready; rdy=0 freezes all state.
REQ-005 req_i  input  1  store request valid.
REQ-006 addr_i  input  32  store byte address.
REQ-007 data_i  input  32  store data; byte 0 is data_i[7:0].
REQ-008 width_i  input  2  store width: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 busy_o  output  1  high while a store is in progress; requests are ignored while high.
REQ-010 done_o  output  1  one-cycle completion pulse.
REQ-011 err_o  output  1  store rejected; valid only while done_o=1.
REQ-012 stall_RAM_i  input  1  RAM is occupied by another master this cycle.
REQ-013 addr_RAM_o  output  32  RAM byte address.
REQ-014 data_RAM_o  output  8  RAM write byte.
REQ-015 wr_RAM_o  output  1  write strobe; 1 means a write of data_RAM_o to addr_RAM_o.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WRITE and DONE; busy_o SHALL equal (state != IDLE).
REQ-017 In IDLE, with rdy=1 and req_i=1, the block SHALL at the clock edge latch addr_i and data_i, set the byte count to 1, 2 or 4 from width_i, and go to WRITE.
REQ-018 In WRITE, the block SHALL drive wr_RAM_o=1, addr_RAM_o = latched address + byte index, and data_RAM_o = latched data byte[index], with bytes written in little-endian order (index 0 first).
REQ-019 A byte SHALL count as written only at an edge where rdy=1 and stall_RAM_i=0; otherwise addr_RAM_o, data_RAM_o and the index SHALL hold, and the same byte SHALL be presented again.
REQ-020 The edge that writes the last byte SHALL move the FSM to DONE and clear wr_RAM_o.
REQ-021 In DONE, done_o SHALL be 1 for exactly one cycle, and the next edge with rdy=1 SHALL return the FSM to IDLE.
REQ-022 Unstalled latency SHALL be as follows, with E0 the accept edge: bytes on the bus in cycles 1..N, done_o in cycle N+1, and a new request accepted no earlier than the cycle after DONE.
REQ-023 Address increment SHALL be modulo 2^32, so 0xFFFFFFFF is followed by 0x00000000.
REQ-024 width_i=11 SHALL perform no RAM write: IDLE goes to DONE, then done_o=1 and err_o=1.
REQ-025 In IDLE and DONE, wr_RAM_o SHALL be 0 and addr_RAM_o/data_RAM_o SHALL hold their last values.
REQ-026 When rdy=0, FSM state, index and all outputs SHALL hold, and a pending done_o SHALL be stretched until rdy=1.
REQ-027 Simultaneous stall_RAM_i=1 and rdy=0 SHALL behave as rdy=0.

Reset
REQ-028 When rst=0, the block SHALL enter IDLE and set addr_RAM_o=0, data_RAM_o=0, wr_RAM_o=0, done_o=0, err_o=0, busy_o=0, and index=0.
REQ-029 Reset during WRITE SHALL abort the store with no further RAM writes; bytes already written SHALL remain written.
REQ-030 Reset deassertion SHALL take effect on the next clk edge, and the first request SHALL be accepted no earlier than that edge.

Configuration
REQ-031 The macro MEM_WRITER_ALIGN_CHECK_EN SHALL compile in the misalignment check.
REQ-032 With MEM_WRITER_ALIGN_CHECK_EN defined, a halfword with addr_i[0]=1 or a word with addr_i[1:0]!=00 SHALL perform no RAM write and SHALL go IDLE -> DONE with err_o=1.
REQ-033 Without MEM_WRITER_ALIGN_CHECK_EN, a misaligned store SHALL be written byte by byte from addr_i, and err_o SHALL be 1 only for width_i=11.

Verification
REQ-034 A word store with addr_i=0x00001000 and data_i=0xDEADBEEF, unstalled, SHALL write EF@0x1000, BE@0x1001, AD@0x1002 and DE@0x1003 in cycles 1-4, with done_o=1 in cycle 5 and err_o=0.
REQ-035 A byte store with addr_i=0x20 and data_i=0x12345678 SHALL write one byte 78@0x20, with done_o in cycle 2.
REQ-036 A halfword store with addr_i=0x40 and data_i=0xAABB, with stall_RAM_i=1 during cycles 1-2, SHALL present BB@0x40 unchanged during cycles 1-3, write AA@0x41 in cycle 4, and assert done_o in cycle 5.
REQ-037 A word store with addr_i=0xFFFFFFFE SHALL write byte addresses FFFFFFFE, FFFFFFFF, 00000000 and 00000001 without the macro, and SHALL write nothing with done_o=1 and err_o=1 in cycle 1 with the macro.
REQ-038 rst=0 asserted in cycle 2 of a word store SHALL clear wr_RAM_o and busy_o immediately, write only byte 0, and produce no done_o pulse.
REQ-039 rdy=0 during cycles 2-3 of a word store SHALL freeze addr and data, and SHALL assert done_o in cycle 7.
